// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 4;

  // Decoder output pattern when nobody holds the resource.
  localparam logic [N_REQ-1:0] Y_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Round-robin pick: first asserted request searching last+1, last+2,
  // last+3, last (mod 4). Walking the candidates from lowest to highest
  // priority lets the highest-priority hit overwrite the result last.
  // Returns last when no request is set; callers gate on |req.
  function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] req,
                                         input logic [1:0]       last);
    logic [1:0] cand;
    rr_pick = last;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last + 2'(k);
      if (req[cand]) rr_pick = cand;
    end
  endfunction

endpackage

// File: rtl/grant_dec.sv
// 2-to-4 select decoder, active-low enable, active-low one-hot outputs.
module grant_dec
  import rr_arb_pkg::*;
(
  input  logic [1:0]       gnt_idx,
  input  logic             en_n_int,
  output logic [N_REQ-1:0] y_dec
);

  // One output bit per requester: low only when enabled and selected.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dec
      assign y_dec[gi] = en_n_int | (gnt_idx != 2'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arb_4.sv
// Four-requester round-robin arbiter with bounded hold time and a one-cycle
// break-before-make gap. All outputs are registered.
module rr_arb_4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] y_n,
  output logic [1:0]       gnt_idx,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [1:0]       gnt_idx_q, gnt_idx_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] y_n_q;
  logic             busy_q;

  logic [1:0]       winner;
  logic             any_req;
  logic             others_req;
  logic             en_n_int;
  logic [N_REQ-1:0] y_dec;

  assign winner     = rr_pick(req, last_q);
  assign any_req    = |req;
  assign others_req = |(req & ~(4'b0001 << gnt_idx_q));

  // Next-state, round-robin load and hold counter.
  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (!en_n && any_req) begin
          state_d    = ST_GRANT;
          gnt_idx_d  = winner;
          last_d     = winner;
          hold_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + 1'b1;
        // Release, hold expiry with a waiting competitor, or disable.
        if (!req[gnt_idx_q] || (hold_cnt_q == HOLD_LAST && others_req) || en_n)
          state_d = ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decoder is fed with next-state values so its registered copy lines up
  // with the state register: y_n is low exactly in GRANT cycles.
  assign en_n_int = (state_d != ST_GRANT);

  grant_dec u_dec (
    .gnt_idx  (gnt_idx_d),
    .en_n_int (en_n_int),
    .y_dec    (y_dec)
  );

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= 2'd0;
      last_q     <= 2'd3;
      hold_cnt_q <= '0;
      y_n_q      <= Y_IDLE;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      y_n_q      <= y_dec;
      busy_q     <= (state_d == ST_GRANT);
    end
  end

  assign y_n     = y_n_q;
  assign gnt_idx = gnt_idx_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_rr_arb_4.sv
// Directed bench for rr_arb_4 with hand-computed expected values.
module tb_rr_arb_4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_n;
  logic [3:0] req;
  logic [3:0] y_n;
  logic [1:0] gnt_idx;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  rr_arb_4 #(.MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_n    (en_n),
    .req     (req),
    .y_n     (y_n),
    .gnt_idx (gnt_idx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    en_n  = 1'b1;
    step();
    rst_n = 1'b1;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0;
    en_n  = 1'b1;
    req   = 4'b0000;

    // Reset then single request
    step();
    step();
    chk("rst y_n", 32'(y_n), 32'hF);
    chk("rst gnt_idx", 32'(gnt_idx), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    en_n  = 1'b0;
    req   = 4'b0100;
    step();
    chk("single y_n", 32'(y_n), 32'hB);
    chk("single gnt_idx", 32'(gnt_idx), 32'd2);
    chk("single busy", 32'(busy), 32'd1);
    req = 4'b0000;
    step();
    chk("single gap y_n", 32'(y_n), 32'hF);
    chk("single gap gnt_idx", 32'(gnt_idx), 32'd2);
    chk("single gap busy", 32'(busy), 32'd0);
    step();
    chk("single idle y_n", 32'(y_n), 32'hF);

    // Round-robin fairness: 8-cycle tenures, 1-cycle gaps
    do_reset();
    en_n = 1'b0;
    req  = 4'b1111;
    step();
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < 8; c++) begin
        chk($sformatf("rr t%0d c%0d y_n", t, c), 32'(y_n), 32'(~(4'b0001 << order[t]) & 4'hF));
        if (c == 0) chk($sformatf("rr t%0d gnt_idx", t), 32'(gnt_idx), 32'(order[t]));
        step();
      end
      chk($sformatf("rr t%0d gap y_n", t), 32'(y_n), 32'hF);
      chk($sformatf("rr t%0d gap busy", t), 32'(busy), 32'd0);
      step();
    end

    // Voluntary release with requester 3 waiting
    do_reset();
    en_n = 1'b0;
    req  = 4'b1010;
    step();
    chk("vol grant1 y_n", 32'(y_n), 32'hD);
    step();
    step();
    req = 4'b1000;
    step();
    chk("vol gap y_n", 32'(y_n), 32'hF);
    step();
    chk("vol grant3 y_n", 32'(y_n), 32'h7);
    chk("vol grant3 gnt_idx", 32'(gnt_idx), 32'd3);

    // No competitor: held indefinitely, counter saturates
    do_reset();
    en_n = 1'b0;
    req  = 4'b0001;
    step();
    for (int c = 0; c < 50; c++) begin
      chk($sformatf("solo c%0d y_n", c), 32'(y_n), 32'hE);
      step();
    end
    chk("solo hold_cnt", 32'(dut.hold_cnt_q), 32'd8);

    // Enable dropped mid-grant: GAP then IDLE
    en_n = 1'b1;
    step();
    chk("en gap y_n", 32'(y_n), 32'hF);
    chk("en gap busy", 32'(busy), 32'd0);
    step();
    chk("en idle y_n", 32'(y_n), 32'hF);
    step();
    chk("en idle2 y_n", 32'(y_n), 32'hF);
    chk("en idle2 busy", 32'(busy), 32'd0);

    // Re-grant to requester 2, then reset mid-grant
    en_n = 1'b0;
    req  = 4'b0100;
    step();
    chk("pre-rst y_n", 32'(y_n), 32'hB);
    rst_n = 1'b0;
    req   = 4'b1010;
    step();
    chk("midrst y_n", 32'(y_n), 32'hF);
    chk("midrst gnt_idx", 32'(gnt_idx), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post-rst y_n", 32'(y_n), 32'hD);
    chk("post-rst gnt_idx", 32'(gnt_idx), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
